// File: rtl/instr_encoder.sv
// instr_encoder: packs opcode, one-hot register selects and immediate into Mini SRC words and emits them with sequential addresses
module instr_encoder #(
  parameter int ADDR_W = 9,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        opcode,
  input  logic              fmt,
  input  logic [15:0]       ra_sel,
  input  logic [15:0]       rb_sel,
  input  logic [15:0]       rc_sel,
  input  logic [31:0]       imm,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_in,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              err,
  output logic [1:0]        err_code
);
  typedef enum logic [1:0] {IDLE, CHECK, EMIT} state_t;
  state_t state, nxt;
  logic [4:0] op;
  logic f;
  logic [15:0] ra, rb, rc;
  logic [31:0] im;
  logic bad_sel, bad_imm;

  function automatic logic one_hot(input logic [15:0] s);
    return (s != 16'd0) && ((s & (s - 16'd1)) == 16'd0);
  endfunction

  function automatic logic [3:0] idx(input logic [15:0] s);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) if (s[i]) r = r | 4'(i);
    return r;
  endfunction

  assign in_ready = state == IDLE;
  assign wr_valid = state == EMIT;

  // validity of the captured request and next-state selection
  always_comb begin
    bad_sel = !one_hot(ra) || !one_hot(rb) || (!f && !one_hot(rc));
    bad_imm = f && (im[31:18] != {14{im[18]}});
    nxt = state;
    nxt = state == IDLE  ? (in_valid ? CHECK : IDLE) :
          state == CHECK ? ((bad_sel || bad_imm) ? IDLE : EMIT) :
                           (wr_ready ? IDLE : EMIT);
  end

  // state register
  always_ff @(posedge clk) begin
    if (!clr_n) state <= IDLE;
    else state <= nxt;
  end

  // capture, encode, error reporting and address counter
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      wr_addr  <= BASE_ADDR;
      wr_data  <= '0;
      err      <= 1'b0;
      err_code <= 2'b00;
      op       <= '0;
      f        <= 1'b0;
      ra       <= '0;
      rb       <= '0;
      rc       <= '0;
      im       <= '0;
    end else begin
      err <= 1'b0;
      if (state == IDLE) begin
        if (addr_load) wr_addr <= addr_in;
        if (in_valid) begin
          op <= opcode;
          f  <= fmt;
          ra <= ra_sel;
          rb <= rb_sel;
          rc <= rc_sel;
          im <= imm;
        end
      end
      if (state == CHECK) begin
        if (bad_sel || bad_imm) begin
          err      <= 1'b1;
          err_code <= bad_sel ? 2'b01 : 2'b10;
        end else
          wr_data <= f ? {op, idx(ra), idx(rb), im[18:0]} : {op, idx(ra), idx(rb), idx(rc), 15'b0};
      end
      if (state == EMIT && wr_ready) wr_addr <= wr_addr + ADDR_W'(1);
    end
  end
endmodule
